render_multi: RTL
=================

RENDER_MULTI -- requirements
Module: render_multi

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 4, number of rectangle objects (1..8).
REQ-002 SHALL have parameter CW, default 4, bits per colour channel.
REQ-003 SHALL have parameter COORD_W, default 10, coordinate width.
REQ-004 SHALL have parameter BACK_COLOR, default 12'h142, background {r,g,b} colour.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk input 1 pixel clock; rst_n input 1 reset.
REQ-006 SHALL have de input 1, display enable for the current pixel.
REQ-007 SHALL have sx and sy, both input COORD_W, the current screen position.
REQ-008 SHALL have frame_start input 1, a one-cycle pulse once per frame during blanking.
REQ-009 SHALL have a write port: wr_valid input 1; wr_ready output 1; wr_idx input clog2(NUM_OBJ) (min 1); wr_x, wr_y, wr_w, wr_h input COORD_W each; wr_color input 3*CW; wr_en input 1 (object visible).
REQ-010 SHALL have commit input 1, requesting shadow-to-active transfer, and pending output 1, high while a commit awaits frame_start.
REQ-011 SHALL have de_out output 1, plus dispcolor_r, dispcolor_g and dispcolor_b output CW each.

Function
REQ-012 SHALL hold per-object shadow and active register sets: x, y, w, h, colour, enable.
REQ-013 SHALL write shadow[wr_idx] on wr_valid && wr_ready; wr_idx >= NUM_OBJ ignored but handshake completes.
REQ-014 SHALL run a control FSM with states OPEN, ARMED and COMMIT.
- OPEN: wr_ready=1.
- ARMED: wr_ready=0, pending=1.
- COMMIT: wr_ready=0; lasts one cycle.
REQ-015 SHALL transition OPEN->ARMED on commit, ARMED->COMMIT on frame_start, and COMMIT->OPEN unconditionally; in COMMIT, active<=shadow for all objects.
REQ-016 SHALL accept a wr_valid coinciding with commit in OPEN; frame_start coinciding with commit in OPEN arms only, with the transfer at the next frame_start; commit in ARMED or COMMIT is ignored.
REQ-017 SHALL compute hit[i] = en && sx>=HA_BACK_PORCH+x && sx<HA_BACK_PORCH+x+w && sy>=VA_BACK_PORCH+y && sy<VA_BACK_PORCH+y+h, evaluated at COORD_W+2 bits without overflow; w=0 or h=0 never hits.
REQ-018 SHALL pipeline the output: stage 1 registers hit[] and de; stage 2 registers the lowest-index hit colour (else BACK_COLOR), gated to 0 when the delayed de=0; latency 2 cycles from sx/sy/de to outputs, and de_out equals de delayed 2.
REQ-019 SHALL make an active-set change take effect from the pixel presented one cycle after COMMIT.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear all shadow and active registers (all objects disabled), set the FSM to OPEN, clear the pipeline, and drive de_out=0, dispcolor_*=0, pending=0 and wr_ready=0 while reset is asserted.
REQ-021 SHALL, on reset mid-ARMED, discard the pending commit; wr_ready=1 on the first clock after release.

Configuration
REQ-022 SHALL, with RENDER_BORDER_EN defined, draw a 1-pixel border of colour 12'hFFF on the first and last active column and row, overriding objects, with the same latency.
REQ-023 SHALL, with RENDER_BORDER_EN undefined, include no border logic and leave output identical to REQ-018.

Structure
REQ-024 SHALL place the HA_/VA_ timing constants, the FSM state enum and an object struct typedef (x, y, w, h, colour, en) in shared package render_pkg.
REQ-025 SHALL implement per-object hit testing in one sub-module, render_obj_hit, instantiated NUM_OBJ times.

Verification
REQ-026 SHALL cover reset: rst_n low with de=1 -> dispcolor=0, de_out=0, pending=0.
REQ-027 SHALL cover a basic object: write obj0 x=10 y=20 w=4 h=2 colour 12'h63F, commit, frame_start; pixel (HA_BACK_PORCH+10, VA_BACK_PORCH+20) -> 6/3/F two cycles later, and column +14 -> 1/4/2.
REQ-028 SHALL cover overlap: obj0 and obj1 overlap, colours 12'h111 and 12'h222 -> overlap pixels 1/1/1.
REQ-029 SHALL cover the handshake: commit then wr_valid -> wr_ready=0 and write stalls until the COMMIT cycle ends; the write then lands in shadow only, and displayed pixels are unchanged.
REQ-030 SHALL cover edge cases: w=0 object -> never drawn; x=1020 w=10 -> drawn to sx max with no wraparound at low sx.
REQ-031 SHALL cover the border: with RENDER_BORDER_EN defined, the first active pixel -> F/F/F; without it -> background.

Source files
------------

// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// render_pkg
// Shared timing constants, control FSM state type and object record for the
// multi-object rectangle renderer.
// Revision: 1.0
// ============================================================================
package render_pkg;

    // Screen timing: sx/sy count from the start of back porch.
    localparam int HA_BACK_PORCH = 2;
    localparam int HA_ACTIVE     = 640;
    localparam int VA_BACK_PORCH = 2;
    localparam int VA_ACTIVE     = 480;

    // Object record widths; COORD_W and CW of render_multi must match these.
    localparam int OBJ_COORD_W = 10;
    localparam int OBJ_CW      = 4;
    localparam int OBJ_COL_W   = 3 * OBJ_CW;

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [OBJ_COORD_W-1:0] x;
        logic [OBJ_COORD_W-1:0] y;
        logic [OBJ_COORD_W-1:0] w;
        logic [OBJ_COORD_W-1:0] h;
        logic [OBJ_COL_W-1:0]   colour;
        logic                   en;
    } obj_t;

endpackage
`default_nettype wire

// File: rtl/render_obj_hit.sv
`default_nettype none
// ============================================================================
// render_obj_hit
// Tests whether the current screen position lies inside one rectangle.
// Revision: 1.0
// ============================================================================
module render_obj_hit
    import render_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               i_en,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    input  logic [COORD_W-1:0] i_sx,
    input  logic [COORD_W-1:0] i_sy,
    output logic               o_hit
);

    // Two extra bits hold porch + x + w without wrapping.
    localparam int EW = COORD_W + 2;

    logic [EW-1:0] w_x0;
    logic [EW-1:0] w_x1;
    logic [EW-1:0] w_y0;
    logic [EW-1:0] w_y1;
    logic [EW-1:0] w_sx;
    logic [EW-1:0] w_sy;

    assign w_x0 = EW'(HA_BACK_PORCH) + EW'(i_x);
    assign w_x1 = w_x0 + EW'(i_w);
    assign w_y0 = EW'(VA_BACK_PORCH) + EW'(i_y);
    assign w_y1 = w_y0 + EW'(i_h);
    assign w_sx = EW'(i_sx);
    assign w_sy = EW'(i_sy);

    // A zero width or height makes the half-open range empty.
    assign o_hit = i_en
                && (w_sx >= w_x0) && (w_sx < w_x1)
                && (w_sy >= w_y0) && (w_sy < w_y1);

endmodule
`default_nettype wire

// File: rtl/render_multi.sv
`default_nettype none
// ============================================================================
// render_multi
// Double-buffered multi-rectangle renderer with a two-stage pixel pipeline.
// Optional macro RENDER_BORDER_EN adds a white 1-pixel screen border.
// Revision: 1.0
// ============================================================================
module render_multi
    import render_pkg::*;
#(
    parameter int              NUM_OBJ    = 4,
    parameter int              CW         = 4,
    parameter int              COORD_W    = 10,
    parameter logic [3*CW-1:0] BACK_COLOR = 12'h142,
    localparam int             IDX_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic               frame_start,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_w,
    input  logic [COORD_W-1:0] wr_h,
    input  logic [3*CW-1:0]    wr_color,
    input  logic               wr_en,
    input  logic               commit,
    output logic               pending,
    output logic               de_out,
    output logic [CW-1:0]      dispcolor_r,
    output logic [CW-1:0]      dispcolor_g,
    output logic [CW-1:0]      dispcolor_b
);

    localparam int COL_W = 3 * CW;

    state_e             r_state;
    obj_t               r_shadow [NUM_OBJ];
    obj_t               r_active [NUM_OBJ];
    obj_t               w_wr_obj;
    logic               w_wr_fire;
    logic [NUM_OBJ-1:0] w_hit;
    logic [NUM_OBJ-1:0] r_hit;
    logic               r_de1;
    logic               r_de2;
    logic [COL_W-1:0]   w_obj_color;
    logic [COL_W-1:0]   w_pix_color;
    logic [COL_W-1:0]   r_color;

    // ------------------------------------------------------------------
    // Commit control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OPEN;
        end else begin
            case (r_state)
                ST_OPEN:   if (commit)      r_state <= ST_ARMED;
                ST_ARMED:  if (frame_start) r_state <= ST_COMMIT;
                ST_COMMIT:                  r_state <= ST_OPEN;
                default:                    r_state <= ST_OPEN;
            endcase
        end
    end

    // Ready is held low while reset is asserted even though the state is OPEN.
    assign wr_ready  = rst_n && (r_state == ST_OPEN);
    assign pending   = (r_state == ST_ARMED);
    assign w_wr_fire = wr_valid && wr_ready;

    always_comb begin
        w_wr_obj        = '0;
        w_wr_obj.x      = OBJ_COORD_W'(wr_x);
        w_wr_obj.y      = OBJ_COORD_W'(wr_y);
        w_wr_obj.w      = OBJ_COORD_W'(wr_w);
        w_wr_obj.h      = OBJ_COORD_W'(wr_h);
        w_wr_obj.colour = OBJ_COL_W'(wr_color);
        w_wr_obj.en     = wr_en;
    end

    // Out-of-range indices match no slot, so the handshake completes silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (w_wr_fire && (32'(wr_idx) == i)) r_shadow[i] <= w_wr_obj;
                if (r_state == ST_COMMIT)            r_active[i] <= r_shadow[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit testing
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
        render_obj_hit #(
            .COORD_W (COORD_W)
        ) u_hit (
            .i_en  (r_active[gi].en),
            .i_x   (COORD_W'(r_active[gi].x)),
            .i_y   (COORD_W'(r_active[gi].y)),
            .i_w   (COORD_W'(r_active[gi].w)),
            .i_h   (COORD_W'(r_active[gi].h)),
            .i_sx  (sx),
            .i_sy  (sy),
            .o_hit (w_hit[gi])
        );
    end

    // Lowest index has priority, so scan from the top down and let it win last.
    always_comb begin
        w_obj_color = BACK_COLOR;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (r_hit[i]) w_obj_color = COL_W'(r_active[i].colour);
        end
    end

`ifdef RENDER_BORDER_EN
    logic r_edge1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge1 <= 1'b0;
        end else begin
            r_edge1 <= (sx == COORD_W'(HA_BACK_PORCH))
                    || (sx == COORD_W'(HA_BACK_PORCH + HA_ACTIVE - 1))
                    || (sy == COORD_W'(VA_BACK_PORCH))
                    || (sy == COORD_W'(VA_BACK_PORCH + VA_ACTIVE - 1));
        end
    end

    assign w_pix_color = r_edge1 ? {COL_W{1'b1}} : w_obj_color;
`else
    assign w_pix_color = w_obj_color;
`endif

    // ------------------------------------------------------------------
    // Output pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit   <= '0;
            r_de1   <= 1'b0;
            r_de2   <= 1'b0;
            r_color <= '0;
        end else begin
            r_hit   <= w_hit;
            r_de1   <= de;
            r_de2   <= r_de1;
            r_color <= r_de1 ? w_pix_color : '0;
        end
    end

    assign de_out      = r_de2;
    assign dispcolor_r = r_color[3*CW-1:2*CW];
    assign dispcolor_g = r_color[2*CW-1:CW];
    assign dispcolor_b = r_color[CW-1:0];

endmodule
`default_nettype wire
